// File: rtl/queue_pkg.sv
// Shared widths and ticket helpers for the service-queue front end, FIFO and dispatcher.
package queue_pkg;

  localparam int NW = 4;
  localparam int TW = 4;

  typedef logic [NW-1:0] ticket_t;
  typedef logic [TW-1:0] stime_t;

  localparam ticket_t TICKET_FIRST = ticket_t'(1);
  localparam ticket_t TICKET_LAST  = '1;

  // Ticket 0 means "no customer" on the displays, so the sequence skips it on wrap.
  function automatic ticket_t next_ticket(input ticket_t cur);
    return (cur == TICKET_LAST) ? TICKET_FIRST : cur + ticket_t'(1);
  endfunction

endpackage

// File: rtl/req_slot.sv
// One-deep pending slot for a single arrival source, with reject/drop reporting.
module req_slot
  import queue_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [TW-1:0] t,
  input  logic          grant,
  output logic          p,
  output logic [TW-1:0] s,
  output logic          rej,
  output logic          drop
);

  logic zero_time;
  logic capture;

  assign zero_time = (t == '0);
  // A slot being granted this cycle is free again, so a new arrival can take it.
  assign capture   = req && !zero_time && (!p || grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p    <= 1'b0;
      s    <= '0;
      rej  <= 1'b0;
      drop <= 1'b0;
    end else begin
      rej  <= req && zero_time;
      drop <= req && !zero_time && p && !grant;
      if (capture) begin
        p <= 1'b1;
        s <= t;
      end else if (grant) begin
        p <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ticket_arbiter.sv
// Round-robin arbiter sharing the queue FIFO write port between two arrival sources,
// stamping each admitted customer with a sequential ticket number.
module ticket_arbiter
  import queue_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [TW-1:0] t0,
  input  logic [TW-1:0] t1,
  input  logic          full,
  output logic          we,
  output logic [NW-1:0] wn,
  output logic [TW-1:0] wt,
  output logic [1:0]    pend,
  output logic          rej0,
  output logic          rej1,
  output logic          drop0,
  output logic          drop1
);

  logic          p0;
  logic          p1;
  logic [TW-1:0] s0;
  logic [TW-1:0] s1;
  logic          ptr;
  logic          sel;
  logic          grant_any;
  logic          grant0;
  logic          grant1;
  ticket_t       ticket;

  // Holding off while we is high keeps one write in flight, so full is never stale.
  assign grant_any = !full && !we && (p0 || p1);
  assign sel       = (p0 && p1) ? ptr : p1;
  assign grant0    = grant_any && !sel;
  assign grant1    = grant_any && sel;
  assign pend      = {p1, p0};

  req_slot u_slot0 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req0),
    .t     (t0),
    .grant (grant0),
    .p     (p0),
    .s     (s0),
    .rej   (rej0),
    .drop  (drop0)
  );

  req_slot u_slot1 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req1),
    .t     (t1),
    .grant (grant1),
    .p     (p1),
    .s     (s1),
    .rej   (rej1),
    .drop  (drop1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we     <= 1'b0;
      wn     <= '0;
      wt     <= '0;
      ptr    <= 1'b0;
      ticket <= TICKET_FIRST;
    end else begin
      we <= grant_any;
      if (grant_any) begin
        wn     <= ticket;
        wt     <= sel ? s1 : s0;
        ptr    <= !sel;
        ticket <= next_ticket(ticket);
      end
    end
  end

endmodule
